// File: rtl/wb_pkg.sv
// Shared types for the register-file write-back path.
// Both the controller and the late-result FIFO use the entry format defined here.
package wb_pkg;
  localparam int XLEN  = 32;
  localparam int REG_W = 5;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Late-result FIFO: push lands on the next edge; dout shows the head combinationally.
// Push while full and pop while empty are ignored; the producer is throttled through count/full.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  wb_entry_t                  din,
  output wb_entry_t                  dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);

  wb_entry_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/wb_ctrl.sv
// Register-file write port owner: ALU results (1 cycle) win over queued late results (2 cycles min).
// Late port stalls via lu_ready when the FIFO is full; issue stalls via iss_ready on a busy destination.
module wb_ctrl #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            iss_valid,
  input  logic            iss_long,
  input  logic [4:0]      iss_rd,
  output logic            iss_ready,
  input  logic [4:0]      q_ra,
  input  logic [4:0]      q_rb,
  output logic            ra_busy,
  output logic            rb_busy,
  input  logic            alu_wr,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_d,
  input  logic            lu_valid,
  input  logic [4:0]      lu_rd,
  input  logic [XLEN-1:0] lu_d,
  output logic            lu_ready,
  output logic            rf_wr,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_d,
  output logic            sb_err
);
  import wb_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   busy;
  logic [31:0]   busy_nxt;
  logic          rf_late;
  wb_entry_t     din;
  wb_entry_t     head;
  logic [CW-1:0] fill;
  logic          full;
  logic          empty;
  logic          alu_go;
  logic          lu_acc;
  logic          push;
  logic          pop;

  assign alu_go    = alu_wr && (alu_rd != '0);
  assign lu_ready  = rst && (fill < CW'(DEPTH));
  assign lu_acc    = lu_valid && lu_ready;
  assign push      = lu_acc && (lu_rd != '0) && !full;
  assign pop       = !alu_go && !empty;
  assign din       = {lu_rd, lu_d};
  assign iss_ready = !(iss_valid && iss_long && busy[iss_rd]);
  assign ra_busy   = busy[q_ra];
  assign rb_busy   = busy[q_rb];

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (head),
    .count (fill),
    .full  (full),
    .empty (empty)
  );

  // A late write releases its register on the edge the regfile captures it.
  always_comb begin
    busy_nxt = busy;
    if (rf_wr && rf_late) busy_nxt[rf_rd] = 1'b0;
    if (iss_valid && iss_ready && iss_long && (iss_rd != '0)) busy_nxt[iss_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy    <= '0;
      rf_wr   <= 1'b0;
      rf_late <= 1'b0;
      rf_rd   <= '0;
      rf_d    <= '0;
      sb_err  <= 1'b0;
    end else begin
      busy    <= busy_nxt;
      rf_late <= 1'b0;
      if (lu_acc && (lu_rd != '0) && !busy[lu_rd]) sb_err <= 1'b1;
      if (alu_go) begin
        rf_wr <= 1'b1;
        rf_rd <= alu_rd;
        rf_d  <= alu_d;
      end else if (pop) begin
        rf_wr   <= 1'b1;
        rf_late <= 1'b1;
        rf_rd   <= head.rd;
        rf_d    <= head.data;
      end else begin
        rf_wr <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_wb_ctrl.sv
// Directed bench for wb_ctrl with a scoreboard of expected regfile writes.
module tb_wb_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        iss_valid, iss_long;
  logic [4:0]  iss_rd;
  logic        iss_ready;
  logic [4:0]  q_ra, q_rb;
  logic        ra_busy, rb_busy;
  logic        alu_wr;
  logic [4:0]  alu_rd;
  logic [31:0] alu_d;
  logic        lu_valid;
  logic [4:0]  lu_rd;
  logic [31:0] lu_d;
  logic        lu_ready;
  logic        rf_wr;
  logic [4:0]  rf_rd;
  logic [31:0] rf_d;
  logic        sb_err;

  int total = 0;
  int bad   = 0;

  logic [36:0] late_q [$];
  logic [36:0] e;
  logic        alu_last = 1'b0;
  logic [4:0]  alu_exp_rd;
  logic [31:0] alu_exp_d;

  always #5 clk = ~clk;

  wb_ctrl #(.XLEN(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_long(iss_long), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .q_ra(q_ra), .q_rb(q_rb), .ra_busy(ra_busy), .rb_busy(rb_busy),
    .alu_wr(alu_wr), .alu_rd(alu_rd), .alu_d(alu_d),
    .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_d(lu_d), .lu_ready(lu_ready),
    .rf_wr(rf_wr), .rf_rd(rf_rd), .rf_d(rf_d), .sb_err(sb_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // An ALU write to a nonzero register out of reset must appear one cycle later.
  always @(posedge clk) begin
    alu_last   <= rst && alu_wr && (alu_rd != 5'd0);
    alu_exp_rd <= alu_rd;
    alu_exp_d  <= alu_d;
  end

  // Any other write must be the oldest outstanding late result.
  always @(negedge clk) begin
    if (alu_last) begin
      chk("alu_wr", rf_wr, 1);
      chk("alu_rd", rf_rd, alu_exp_rd);
      chk("alu_d", rf_d, alu_exp_d);
    end else if (rf_wr === 1'b1) begin
      if (late_q.size() == 0) begin
        chk("spurious_wr", rf_wr, 0);
      end else begin
        e = late_q.pop_front();
        chk("late_rd", rf_rd, e[36:32]);
        chk("late_d", rf_d, e[31:0]);
      end
    end
  end

  initial begin
    rst = 1'b0; iss_valid = 1'b0; iss_long = 1'b0; iss_rd = 5'd0;
    q_ra = 5'd7; q_rb = 5'd0;
    alu_wr = 1'b1; alu_rd = 5'd5; alu_d = 32'h5555;
    lu_valid = 1'b0; lu_rd = 5'd0; lu_d = 32'd0;

    // Reset held with ALU traffic
    step(); step();
    mid();
    chk("rst_rf_wr", rf_wr, 0);
    chk("rst_rf_rd", rf_rd, 0);
    chk("rst_rf_d", rf_d, 0);
    chk("rst_lu_ready", lu_ready, 0);
    chk("rst_ra_busy", ra_busy, 0);
    chk("rst_sb_err", sb_err, 0);
    step();
    alu_wr = 1'b0; rst = 1'b1;
    mid();
    chk("rel_lu_ready", lu_ready, 1);
    chk("rel_rf_wr", rf_wr, 0);

    // ALU path and x0 suppression
    step();
    alu_wr = 1'b1; alu_rd = 5'd5; alu_d = 32'hDEADBEEF;
    step();
    alu_rd = 5'd0; alu_d = 32'h11111111;
    mid();
    chk("alu1_wr", rf_wr, 1);
    chk("alu1_rd", rf_rd, 5);
    chk("alu1_d", rf_d, 32'hDEADBEEF);
    step();
    alu_wr = 1'b0;
    mid();
    chk("x0_no_wr", rf_wr, 0);
    chk("x0_hold_rd", rf_rd, 5);

    // Long op to x7, late result, WAW stall window
    step();
    iss_valid = 1'b1; iss_long = 1'b1; iss_rd = 5'd7;
    mid();
    chk("iss7_ready", iss_ready, 1);
    step();
    iss_valid = 1'b0;
    mid();
    chk("x7_busy", ra_busy, 1);
    step();
    lu_valid = 1'b1; lu_rd = 5'd7; lu_d = 32'h1234; late_q.push_back({5'd7, 32'h1234});
    iss_valid = 1'b1;
    mid();
    chk("n0_lu_ready", lu_ready, 1);
    chk("n0_iss_ready", iss_ready, 0);
    chk("n0_busy", ra_busy, 1);
    step();
    lu_valid = 1'b0;
    mid();
    chk("n1_busy", ra_busy, 1);
    chk("n1_iss_ready", iss_ready, 0);
    chk("n1_rf_wr", rf_wr, 0);
    step();
    mid();
    chk("n2_rf_wr", rf_wr, 1);
    chk("n2_rf_rd", rf_rd, 7);
    chk("n2_rf_d", rf_d, 32'h1234);
    chk("n2_busy", ra_busy, 1);
    chk("n2_iss_ready", iss_ready, 0);
    step();
    iss_valid = 1'b0;
    mid();
    chk("n3_busy", ra_busy, 0);
    chk("n3_rf_wr", rf_wr, 0);
    chk("n3_sb_err", sb_err, 0);

    // ALU/late collision
    iss_valid = 1'b1; iss_rd = 5'd4;
    step();
    iss_valid = 1'b0;
    alu_wr = 1'b1; alu_rd = 5'd3; alu_d = 32'hAAAA3333;
    lu_valid = 1'b1; lu_rd = 5'd4; lu_d = 32'hBBBB4444; late_q.push_back({5'd4, 32'hBBBB4444});
    mid();
    chk("col_lu_ready", lu_ready, 1);
    step();
    alu_wr = 1'b0; lu_valid = 1'b0;
    mid();
    chk("col_x3_rd", rf_rd, 3);
    step();
    mid();
    chk("col_x4_rd", rf_rd, 4);
    chk("col_x4_d", rf_d, 32'hBBBB4444);
    step();
    mid();
    chk("col_idle", rf_wr, 0);

    // Fill under continuous ALU traffic, then drain
    for (int i = 1; i <= 4; i++) begin
      iss_valid = 1'b1; iss_long = 1'b1; iss_rd = 5'(i);
      step();
    end
    iss_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      alu_wr = 1'b1; alu_rd = 5'(10 + i); alu_d = 32'(i);
      lu_valid = 1'b1; lu_rd = 5'(i); lu_d = 32'hF000 + 32'(i);
      late_q.push_back({5'(i), 32'hF000 + 32'(i)});
      mid();
      chk("fill_lu_ready", lu_ready, 1);
      step();
    end
    alu_rd = 5'd15; lu_rd = 5'd1; lu_d = 32'hBAD0;
    mid();
    chk("full_lu_ready", lu_ready, 0);
    step();
    alu_wr = 1'b0; lu_valid = 1'b0;
    mid();
    chk("full_pop_lu_ready", lu_ready, 0);
    step();
    mid();
    chk("drain_lu_ready", lu_ready, 1);
    chk("drain_first_rd", rf_rd, 1);
    for (int i = 0; i < 4; i++) step();
    q_ra = 5'd1; q_rb = 5'd4;
    mid();
    chk("drain_q_empty", late_q.size(), 0);
    chk("drain_x1_busy", ra_busy, 0);
    chk("drain_x4_busy", rb_busy, 0);

    // Late result for a register that was never issued long
    chk("pre_sb_err", sb_err, 0);
    step();
    lu_valid = 1'b1; lu_rd = 5'd9; lu_d = 32'h9999; late_q.push_back({5'd9, 32'h9999});
    step();
    lu_valid = 1'b0;
    mid();
    chk("sb_err_set", sb_err, 1);
    for (int i = 0; i < 3; i++) step();
    mid();
    chk("sb_err_sticky", sb_err, 1);
    chk("x9_written", late_q.size(), 0);

    // Reset with three entries queued
    for (int i = 11; i <= 13; i++) begin
      iss_valid = 1'b1; iss_long = 1'b1; iss_rd = 5'(i);
      step();
    end
    iss_valid = 1'b0;
    for (int i = 11; i <= 13; i++) begin
      alu_wr = 1'b1; alu_rd = 5'd20; alu_d = 32'(i);
      lu_valid = 1'b1; lu_rd = 5'(i); lu_d = 32'hE000 + 32'(i);
      step();
    end
    rst = 1'b0; alu_wr = 1'b0; lu_valid = 1'b0;
    late_q.delete();
    step();
    rst = 1'b1; q_ra = 5'd11; q_rb = 5'd12;
    iss_valid = 1'b1; iss_long = 1'b1; iss_rd = 5'd13;
    mid();
    chk("mrst_rf_wr", rf_wr, 0);
    chk("mrst_rf_rd", rf_rd, 0);
    chk("mrst_rf_d", rf_d, 0);
    chk("mrst_sb_err", sb_err, 0);
    chk("mrst_x11_busy", ra_busy, 0);
    chk("mrst_x12_busy", rb_busy, 0);
    chk("mrst_x13_ready", iss_ready, 1);
    step();
    iss_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    mid();
    chk("mrst_lu_ready", lu_ready, 1);
    chk("mrst_rf_idle", rf_wr, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_ctrl.md
# wb_ctrl

Write-back controller that owns the single write port of the RV32I register file. It merges single-cycle ALU results with late results from multi-cycle units (load/store, divider) through a small result FIFO. It keeps a per-register busy scoreboard so issue logic can stall on RAW/WAW hazards. It sits between the execute stage and the register file's `rd`/`rd_d`/`wr` inputs.

## Interface
Parameters:
- `XLEN`, 32: data width.
- `DEPTH`, 4: late-result FIFO entries (power of two, ≥2).

Ports:
- `clk`, in, 1: core clock; all state on rising edge.
- `rst`, in, 1: reset, synchronous, active-low (state cleared on the rising `clk` edge where `rst == 0`).
- `iss_valid`, in, 1: instruction issuing this cycle.
- `iss_long`, in, 1: issuing instruction's result returns via the late port.
- `iss_rd`, in, 5: destination of issuing instruction.
- `iss_ready`, out, 1: issue may proceed.
- `q_ra`, in, 5: scoreboard query A.
- `q_rb`, in, 5: scoreboard query B.
- `ra_busy`, out, 1: register `q_ra` has a pending late write.
- `rb_busy`, out, 1: register `q_rb` has a pending late write.
- `alu_wr`, in, 1: ALU result valid this cycle.
- `alu_rd`, in, 5: ALU result destination.
- `alu_d`, in, XLEN: ALU result data.
- `lu_valid`, in, 1: late result valid.
- `lu_rd`, in, 5: late result destination.
- `lu_d`, in, XLEN: late result data.
- `lu_ready`, out, 1: late result accepted when `lu_valid & lu_ready`.
- `rf_wr`, out, 1: register-file write enable (registered).
- `rf_rd`, out, 5: register-file write address (registered).
- `rf_d`, out, XLEN: register-file write data (registered).
- `sb_err`, out, 1: sticky; a late result arrived for a non-busy register.

## Operation
- Reset, `rst == 0`:
  - `rf_wr`, `rf_rd`, `rf_d`, `sb_err` are 0.
  - All busy bits are cleared and the FIFO is emptied; any pending data is discarded.
  - `lu_ready` is 0 while `rst == 0`. `iss_ready` reflects the cleared scoreboard.
- Port arbitration each cycle:
  - `alu_wr & alu_rd != 0` has priority: next cycle `rf_wr=1`, `rf_rd=alu_rd`, `rf_d=alu_d`.
  - Otherwise, if the FIFO is non-empty, the head entry is popped and driven the same way.
  - Otherwise `rf_wr=0`; `rf_rd`/`rf_d` hold their last values.
- ALU writes to x0 are suppressed (`rf_wr=0`) and give the FIFO the port that cycle.
- Enqueue:
  - `lu_ready = (count < DEPTH)`. There is no pass-through when full, even if a pop happens in the same cycle.
  - An accepted entry with `lu_rd == 0` is consumed and dropped: no FIFO entry, no write.
- Scoreboard:
  - A busy bit is set on the edge where `iss_valid & iss_ready & iss_long & iss_rd != 0`.
  - It is cleared on the edge where the regfile captures that register's late write, i.e. the edge ending the `rf_wr` cycle for the popped entry.
  - x0 is never busy.
- `iss_ready = !(iss_valid & iss_long & busy[iss_rd])`. This is a WAW stall; the clear and the new set never occur on the same edge.
- `ra_busy = busy[q_ra]`, `rb_busy = busy[q_rb]` (combinational). Both are 0 for x0.
- `sb_err` is set on acceptance of a late result with `lu_rd != 0` and `busy[lu_rd] == 0`. The entry is still written. `sb_err` clears only on reset.
- FIFO pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH. `count` is `$clog2(DEPTH)+1` bits.
- Simultaneous push and pop keeps `count` unchanged.

## Timing
- ALU path latency: 1 cycle, `alu_wr` at cycle N gives `rf_wr` at N+1.
- Late path latency, FIFO empty and no ALU traffic: 2 cycles, accepted at N, popped at N+1, `rf_wr` at N+2.
- The busy bit for a late write falls at the end of the `rf_wr` cycle (N+2). Readers see the new regfile value from cycle N+3.
- ALU traffic delays FIFO drain by exactly one cycle per ALU write. Drain order is FIFO order.
- Reset asserted mid-operation takes effect on that edge. Outputs are 0 in the following cycle.

## Structure
- Package `wb_pkg`:
  - `XLEN`, `REG_W = 5`.
  - `typedef struct packed { logic [REG_W-1:0] rd; logic [XLEN-1:0] data; } wb_entry_t`.
- Sub-module `wb_fifo`:
  - Synchronous FIFO of `wb_entry_t`, same `clk`/`rst`.
  - Ports `push`, `pop`, `din`, `dout`, `count`, `full`, `empty`.
- Scoreboard (32-bit busy vector) and arbitration live in `wb_ctrl`.

## Test plan
- Reset: hold `rst=0` with `alu_wr=1` → `rf_wr=0`, `lu_ready=0`, `ra_busy=0`. After release, `lu_ready=1`.
- ALU write `alu_rd=5`, `alu_d=32'hDEADBEEF` at N → `rf_wr=1`, `rf_rd=5`, `rf_d=32'hDEADBEEF` at N+1. `alu_rd=0` → no write.
- Issue long to x7; late result `x7=32'h1234` accepted at N, ALU idle:
  - `ra_busy(q_ra=7)` stays 1 through N+2 and is 0 at N+3.
  - `rf_wr` occurs at N+2.
  - A second long issue to x7 during N..N+2 sees `iss_ready=0`.
- Collision: `alu_wr` (x3) and late result (x4) accepted in the same cycle with the FIFO empty → x3 written at N+1, x4 at N+2.
- Fill: push DEPTH late results to x1..x4 under continuous `alu_wr` → `lu_ready=0` at count 4. Drop `alu_wr` → writes drain x1,x2,x3,x4 in order and `lu_ready` returns to 1.
- Late result to non-busy x9 → `sb_err=1` and stays set, x9 is still written. Reset with 3 entries queued → no further writes and all busy bits are 0.
